vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Transaction controller for the coin-operated selling machine.
- Accumulates credit from the debounced coin encoder and accepts an item selection.
- Sequences a product-dispense handshake, then pays change one half-yuan coin at a time through a change-dispenser handshake.
- Refunds credit on cancel or inactivity timeout. Runs on the fast system clock; the slow divided clock arrives as a one-cycle tick enable.

Parameters:
- CW, 5, credit width in half-yuan units.
- PRICE0, 3, item 0 price in half-yuan units (1.5 yuan).
- PRICE1, 5, item 1 price in half-yuan units (2.5 yuan).
- MAX_CREDIT, 10, credit ceiling in half-yuan units; must be < 2^CW.
- TIMEOUT, 15, idle ticks before automatic refund; range 1..255.

Ports:
- clk  in  1  system clock; single clock domain.
- clr  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide slow time enable.
- coin_vld  in  1  one-clk coin event.
- coin_code  in  2  01 = 0.5 yuan (1 unit), 10 = 1 yuan (2 units), 00/11 invalid.
- item_vld  in  1  one-clk selection event.
- item_sel  in  1  0 = item 0, 1 = item 1.
- cancel  in  1  one-clk refund request.
- vend_ack  in  1  dispenser done; sampled only while vend_req = 1.
- chg_ack  in  1  one half-yuan coin ejected; sampled only while chg_req = 1.
- credit  out  CW  current credit, for the 7-segment display.
- vend_req  out  1  dispense request, level.
- vend_item  out  1  item being dispensed; stable while vend_req = 1.
- chg_req  out  1  change/refund coin request, level.
- coin_rej  out  1  one-clk pulse: coin refused (mechanically returned).
- busy  out  1  high in VEND, CHANGE, REFUND.

Behaviour:
- States: IDLE, CREDIT, VEND, CHANGE, REFUND. All registers update on posedge clk.
- clr = 1: state = IDLE, credit = 0, idle counter = 0. All outputs are 0 on the next edge. clr overrides everything, including mid-handshake; no ack is awaited.
- Coin acceptance, IDLE or CREDIT only:
  - coin_vld with valid code: credit += value. Go to CREDIT, idle counter cleared.
  - Sum > MAX_CREDIT: credit unchanged, coin_rej pulses.
  - Invalid code: ignored, no coin_rej.
- Coins while busy: coin_rej pulses, credit unchanged.
- Priority when events coincide in CREDIT: cancel > item_vld > coin_vld. A lower-priority coin in the same cycle is rejected (coin_rej = 1).
- IDLE: item_vld and cancel ignored. The idle counter does not run.
- CREDIT:
  - item_vld with credit >= price(item_sel): latch vend_item, credit -= price, go to VEND.
  - item_vld with credit < price: ignored, idle counter cleared.
  - cancel: go to REFUND.
  - Each tick increments the idle counter. Reaching TIMEOUT goes to REFUND.
  - If credit is 0 in CREDIT, return to IDLE. This cannot occur by construction; the check is a guard.
- VEND:
  - vend_req = 1 from the first cycle in VEND.
  - On vend_ack: vend_req drops next cycle. If credit > 0 go to CHANGE, else go to IDLE.
  - cancel and tick are ignored in VEND.
- CHANGE and REFUND behave identically:
  - chg_req = 1 while credit > 0.
  - Each cycle with chg_ack = 1: credit -= 1.
  - chg_req deasserts in the same cycle that credit reaches 0 (registered), then state goes to IDLE.
  - Back-to-back acks on consecutive cycles are legal; one unit is paid per ack.
- Latencies:
  - coin_vld to credit updated: 1 clk.
  - item_vld to vend_req high: 1 clk.
  - vend_ack to chg_req high: 1 clk.
- Arithmetic: unsigned, CW bits. Credit never underflows: subtraction happens only after the >= compare, or while credit > 0. Credit never exceeds MAX_CREDIT.
- tick coinciding with a coin: the coin clears the counter; the clear wins.
- An ack asserted outside its req window is ignored.

Test Plan:
- Reset, then coin 10, 10, 01 -> credit 2, 4, 5. item_vld sel=1 -> vend_req = 1, vend_item = 1, credit 0. vend_ack -> IDLE, no chg_req.
- Credit 4, select item 0 (price 3) -> VEND, then vend_ack. CHANGE: chg_req = 1, one chg_ack -> credit 0, chg_req = 0, IDLE.
- Credit 9, coin 10 -> coin_rej pulse, credit stays 9. Coin 01 -> credit 10. Coin 01 -> rejected.
- Credit 2, select item 1 -> no vend, credit stays 2. Then 15 ticks with no events -> REFUND, two chg_acks -> credit 0, IDLE.
- Credit 3: cancel, item_vld and coin_vld in the same cycle -> REFUND, coin_rej = 1, credit 3 refunded over 3 acks. Coin during REFUND -> coin_rej.
- clr asserted in VEND with vend_req = 1 -> next cycle: vend_req 0, credit 0, IDLE. A later vend_ack is ignored.

Source files
------------

// File: rtl/vend_sequencer.sv
// vend_sequencer
//   Transaction controller for the coin-operated selling machine. Accumulates
//   credit from the coin encoder, accepts an item selection, runs the product
//   dispense handshake, then pays change (or a refund) one half-yuan coin at a
//   time through the change-dispenser handshake. Everything runs on clk; the
//   slow time base arrives as the one-cycle 'tick' enable.
//
// Ports
//   clk        system clock
//   clr        synchronous active-high reset
//   tick       one-clk slow time enable (drives the inactivity timer)
//   coin_vld   one-clk coin event, coin_code 01 = 1 unit, 10 = 2 units
//   item_vld   one-clk selection event, item_sel picks item 0 / item 1
//   cancel     one-clk refund request
//   vend_ack   dispenser done, honoured only while vend_req = 1
//   chg_ack    one change coin ejected, honoured only while chg_req = 1
//   credit     current credit in half-yuan units
//   vend_req   dispense request level, vend_item = item being dispensed
//   chg_req    change/refund coin request level
//   coin_rej   one-clk pulse, coin mechanically returned
//   busy       high while dispensing, paying change or refunding
module vend_sequencer #(
   parameter int unsigned CW         = 5,
   parameter int unsigned PRICE0     = 3,
   parameter int unsigned PRICE1     = 5,
   parameter int unsigned MAX_CREDIT = 10,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          tick,
   input  logic          coin_vld,
   input  logic [1:0]    coin_code,
   input  logic          item_vld,
   input  logic          item_sel,
   input  logic          cancel,
   input  logic          vend_ack,
   input  logic          chg_ack,
   output logic [CW-1:0] credit,
   output logic          vend_req,
   output logic          vend_item,
   output logic          chg_req,
   output logic          coin_rej,
   output logic          busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CREDIT,
      S_VEND,
      S_CHANGE,
      S_REFUND
   } state_t;

   localparam logic [CW:0]   MAX_C     = MAX_CREDIT[CW:0];
   localparam logic [CW-1:0] PRICE0_C  = PRICE0[CW-1:0];
   localparam logic [CW-1:0] PRICE1_C  = PRICE1[CW-1:0];
   localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [7:0]    TIMEOUT_C = TIMEOUT[7:0];

   state_t        state_q,     state_d;
   logic [CW-1:0] credit_q,    credit_d;
   logic [7:0]    idle_cnt_q,  idle_cnt_d;
   logic          vend_req_q,  vend_req_d;
   logic          vend_item_q, vend_item_d;
   logic          chg_req_q,   chg_req_d;
   logic          coin_rej_q,  coin_rej_d;
   logic          busy_q,      busy_d;

   logic [1:0]    coin_units;
   logic          coin_ok;
   logic [CW:0]   coin_sum;
   logic [CW-1:0] price;

   always_comb begin
      unique case (coin_code)
         2'b01:   coin_units = 2'd1;
         2'b10:   coin_units = 2'd2;
         default: coin_units = 2'd0;
      endcase
      coin_ok  = coin_vld && (coin_units != 2'd0);
      // one extra bit so the ceiling compare cannot wrap
      coin_sum = {1'b0, credit_q} + {{(CW-1){1'b0}}, coin_units};
      price    = item_sel ? PRICE1_C : PRICE0_C;
   end

   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      idle_cnt_d  = idle_cnt_q;
      vend_item_d = vend_item_q;
      coin_rej_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (coin_ok) begin
               if (coin_sum > MAX_C) begin
                  coin_rej_d = 1'b1;
               end else begin
                  credit_d   = coin_sum[CW-1:0];
                  idle_cnt_d = '0;
                  state_d    = S_CREDIT;
               end
            end
         end

         S_CREDIT: begin
            if (credit_q == '0) begin
               // unreachable guard: an empty session falls back to idle
               idle_cnt_d = '0;
               state_d    = S_IDLE;
            end else if (cancel) begin
               coin_rej_d = coin_ok;
               idle_cnt_d = '0;
               state_d    = S_REFUND;
            end else if (item_vld) begin
               // selection outranks a coin in the same cycle, even when it
               // turns out to be unaffordable
               coin_rej_d = coin_ok;
               idle_cnt_d = '0;
               if (credit_q >= price) begin
                  credit_d    = credit_q - price;
                  vend_item_d = item_sel;
                  state_d     = S_VEND;
               end
            end else if (coin_ok && (coin_sum <= MAX_C)) begin
               // accepted coin clears the timer, winning over a same-cycle tick
               credit_d   = coin_sum[CW-1:0];
               idle_cnt_d = '0;
            end else begin
               coin_rej_d = coin_ok;
               if (tick) begin
                  if (idle_cnt_q + 8'd1 >= TIMEOUT_C) begin
                     idle_cnt_d = '0;
                     state_d    = S_REFUND;
                  end else begin
                     idle_cnt_d = idle_cnt_q + 8'd1;
                  end
               end
            end
         end

         S_VEND: begin
            coin_rej_d = coin_ok;
            if (vend_req_q && vend_ack) begin
               state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
         end

         S_CHANGE, S_REFUND: begin
            coin_rej_d = coin_ok;
            if (credit_q == '0) begin
               state_d = S_IDLE;
            end else if (chg_req_q && chg_ack) begin
               credit_d = credit_q - ONE_C;
               if (credit_q == ONE_C) begin
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            state_d    = S_IDLE;
            credit_d   = '0;
            idle_cnt_d = '0;
         end
      endcase

      // outputs are registered from the next-state view
      vend_req_d = (state_d == S_VEND);
      chg_req_d  = ((state_d == S_CHANGE) || (state_d == S_REFUND)) && (credit_d != '0);
      busy_d     = (state_d == S_VEND) || (state_d == S_CHANGE) || (state_d == S_REFUND);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_IDLE;
         credit_q    <= '0;
         idle_cnt_q  <= '0;
         vend_req_q  <= 1'b0;
         vend_item_q <= 1'b0;
         chg_req_q   <= 1'b0;
         coin_rej_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         idle_cnt_q  <= idle_cnt_d;
         vend_req_q  <= vend_req_d;
         vend_item_q <= vend_item_d;
         chg_req_q   <= chg_req_d;
         coin_rej_q  <= coin_rej_d;
         busy_q      <= busy_d;
      end
   end

   assign credit    = credit_q;
   assign vend_req  = vend_req_q;
   assign vend_item = vend_item_q;
   assign chg_req   = chg_req_q;
   assign coin_rej  = coin_rej_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer
//   Drives vend_sequencer with the directed scenarios of the transaction flow
//   followed by randomized traffic. A behavioural model of the machine turns
//   each applied input cycle into the output set expected one clock later;
//   a separate monitor pops and checks those against the DUT outputs.
module tb_vend_sequencer;

   localparam int CW         = 5;
   localparam int PRICE0     = 3;
   localparam int PRICE1     = 5;
   localparam int MAX_CREDIT = 10;
   localparam int TIMEOUT    = 15;

   typedef struct packed {
      logic [CW-1:0] credit;
      logic          vend_req;
      logic          vend_item;
      logic          chg_req;
      logic          coin_rej;
      logic          busy;
   } obs_t;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          tick = 1'b0;
   logic          coin_vld = 1'b0;
   logic [1:0]    coin_code = 2'b00;
   logic          item_vld = 1'b0;
   logic          item_sel = 1'b0;
   logic          cancel = 1'b0;
   logic          vend_ack = 1'b0;
   logic          chg_ack = 1'b0;
   logic [CW-1:0] credit;
   logic          vend_req;
   logic          vend_item;
   logic          chg_req;
   logic          coin_rej;
   logic          busy;

   vend_sequencer #(
      .CW        (CW),
      .PRICE0    (PRICE0),
      .PRICE1    (PRICE1),
      .MAX_CREDIT(MAX_CREDIT),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .tick     (tick),
      .coin_vld (coin_vld),
      .coin_code(coin_code),
      .item_vld (item_vld),
      .item_sel (item_sel),
      .cancel   (cancel),
      .vend_ack (vend_ack),
      .chg_ack  (chg_ack),
      .credit   (credit),
      .vend_req (vend_req),
      .vend_item(vend_item),
      .chg_req  (chg_req),
      .coin_rej (coin_rej),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // behavioural model: credit plus what the machine is currently doing
   int   m_credit  = 0;
   int   m_idle    = 0;
   bit   m_session = 1'b0;  // holding credit, waiting for a choice
   bit   m_vending = 1'b0;  // dispenser handshake in progress
   bit   m_paying  = 1'b0;  // paying change or refund
   bit   m_item    = 1'b0;

   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic model_step(input bit c_clr, input bit c_tick, input bit c_cv,
                             input bit [1:0] c_code, input bit c_iv, input bit c_is,
                             input bit c_cn, input bit c_va, input bit c_ca);
      int   val;
      int   price;
      bit   rej;
      obs_t e;
      val   = (c_code == 2'd1) ? 1 : (c_code == 2'd2) ? 2 : 0;
      price = c_is ? PRICE1 : PRICE0;
      rej   = 1'b0;
      if (c_clr) begin
         m_credit = 0; m_idle = 0; m_session = 0; m_vending = 0; m_paying = 0; m_item = 0;
      end else if (m_vending) begin
         rej = c_cv && (val > 0);
         if (c_va) begin
            m_vending = 0;
            if (m_credit > 0) m_paying = 1;
         end
      end else if (m_paying) begin
         rej = c_cv && (val > 0);
         if (m_credit == 0) m_paying = 0;
         else if (c_ca) begin
            m_credit = m_credit - 1;
            if (m_credit == 0) m_paying = 0;
         end
      end else if (m_session && c_cn) begin
         rej = c_cv && (val > 0);
         m_session = 0; m_paying = 1; m_idle = 0;
      end else if (m_session && c_iv) begin
         rej = c_cv && (val > 0);
         m_idle = 0;
         if (m_credit >= price) begin
            m_credit = m_credit - price;
            m_item = c_is; m_session = 0; m_vending = 1;
         end
      end else if (c_cv && (val > 0) && (m_credit + val <= MAX_CREDIT)) begin
         m_credit = m_credit + val; m_session = 1; m_idle = 0;
      end else begin
         rej = c_cv && (val > 0);
         if (m_session && c_tick) begin
            m_idle = m_idle + 1;
            if (m_idle >= TIMEOUT) begin
               m_session = 0; m_paying = 1; m_idle = 0;
            end
         end
      end
      e.credit    = m_credit[CW-1:0];
      e.vend_req  = m_vending;
      e.vend_item = m_item;
      e.chg_req   = m_paying && (m_credit > 0);
      e.coin_rej  = rej;
      e.busy      = m_vending || m_paying;
      exp_q.push_back(e);
   endtask

   // apply one cycle of inputs on the falling edge and queue its expectation
   task automatic drv(input bit c_clr, input bit c_tick, input bit c_cv,
                      input bit [1:0] c_code, input bit c_iv, input bit c_is,
                      input bit c_cn, input bit c_va, input bit c_ca);
      @(negedge clk);
      clr = c_clr; tick = c_tick; coin_vld = c_cv; coin_code = c_code;
      item_vld = c_iv; item_sel = c_is; cancel = c_cn; vend_ack = c_va; chg_ack = c_ca;
      model_step(c_clr, c_tick, c_cv, c_code, c_iv, c_is, c_cn, c_va, c_ca);
   endtask

   task automatic idle_cyc();        drv(0,0,0,2'b00,0,0,0,0,0); endtask
   task automatic coin(input bit [1:0] c); drv(0,0,1,c,0,0,0,0,0); endtask
   task automatic sel(input bit s);  drv(0,0,0,2'b00,1,s,0,0,0); endtask
   task automatic vack();            drv(0,0,0,2'b00,0,0,0,1,0); endtask
   task automatic cack();            drv(0,0,0,2'b00,0,0,0,0,1); endtask
   task automatic tck();             drv(0,1,0,2'b00,0,0,0,0,0); endtask
   task automatic rst();             drv(1,0,0,2'b00,0,0,0,0,0); endtask

   // monitor: every registered output set is checked one step after its inputs
   initial begin
      obs_t e;
      obs_t a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.credit = credit; a.vend_req = vend_req; a.vend_item = vend_item;
            a.chg_req = chg_req; a.coin_rej = coin_rej; a.busy = busy;
            n_cmp++;
            if (a !== e) begin
               n_err++;
               $display("FAIL outputs t=%0t got credit=%0d vreq=%b item=%b creq=%b rej=%b busy=%b, want credit=%0d vreq=%b item=%b creq=%b rej=%b busy=%b",
                        $time, a.credit, a.vend_req, a.vend_item, a.chg_req, a.coin_rej, a.busy,
                        e.credit, e.vend_req, e.vend_item, e.chg_req, e.coin_rej, e.busy);
            end
         end
      end
   end

   initial begin
      // exact sale of item 1 with 2+2+1 units
      rst(); rst();
      coin(2'b10); coin(2'b10); coin(2'b01);
      sel(1); idle_cyc(); idle_cyc(); vack(); idle_cyc(); idle_cyc();

      // item 0 from 4 units, one coin of change
      coin(2'b10); coin(2'b10); sel(0); idle_cyc(); vack(); idle_cyc(); cack(); idle_cyc(); idle_cyc();

      // credit ceiling: 9, reject +2, accept +1 to 10, reject +1, invalid codes ignored
      for (int i = 0; i < 4; i++) coin(2'b10);
      coin(2'b01); coin(2'b10); coin(2'b01); coin(2'b01); coin(2'b11); coin(2'b00);
      drv(0,0,0,2'b00,0,0,1,0,0);
      for (int i = 0; i < 10; i++) cack();
      idle_cyc(); idle_cyc();

      // unaffordable selection, then inactivity refund; stray acks before it
      coin(2'b10); sel(1); vack(); cack();
      for (int i = 0; i < TIMEOUT; i++) tck();
      idle_cyc(); cack(); cack(); idle_cyc(); idle_cyc();

      // cancel beats selection and coin in the same cycle; coin during refund
      coin(2'b10); coin(2'b01);
      drv(0,0,1,2'b10,1,0,1,0,0);
      coin(2'b10); cack(); cack(); cack(); idle_cyc(); idle_cyc();

      // tick coinciding with a coin: the coin clears the timer
      coin(2'b01);
      for (int i = 0; i < TIMEOUT - 1; i++) tck();
      drv(0,1,1,2'b01,0,0,0,0,0);
      for (int i = 0; i < TIMEOUT - 1; i++) tck();
      tck(); cack(); cack(); idle_cyc();

      // reset in the middle of a dispense; late ack ignored
      coin(2'b10); coin(2'b10); sel(0); idle_cyc(); rst(); vack(); idle_cyc(); idle_cyc();

      // randomized traffic, first busy and coin-heavy, then sparse to reach timeouts
      for (int i = 0; i < 2500; i++) begin
         bit       r_clr, r_tick, r_cv, r_iv, r_is, r_cn, r_va, r_ca;
         bit [1:0] r_code;
         int       coin_pct;
         coin_pct = (i < 1500) ? 30 : 3;
         r_clr  = ($urandom_range(399) == 0);
         r_tick = ($urandom_range(99) < ((i < 1500) ? 20 : 60));
         r_cv   = ($urandom_range(99) < coin_pct);
         r_code = 2'($urandom_range(3));
         r_iv   = ($urandom_range(99) < 10);
         r_is   = 1'($urandom_range(1));
         r_cn   = ($urandom_range(99) < 3);
         r_va   = ($urandom_range(99) < 30);
         r_ca   = ($urandom_range(99) < 50);
         drv(r_clr, r_tick, r_cv, r_code, r_iv, r_is, r_cn, r_va, r_ca);
      end
      idle_cyc();

      // bounded drain of the outstanding expectations
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain got %0d pending expectations, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
